score_report_tx: RTL and testbench
==================================

# score_report_tx

Serial transmitter that reports the basketball scoreboard state to a host over an 8N1 UART line. On a one-cycle `send` request it snapshots team A score, team B score and remaining game time, formats them as a fixed 13-byte ASCII frame, and shifts the frame out LSB-first. It is the outbound counterpart to the board's pushbutton/seven-segment user interface. It sits beside the scoring logic in the same 12 MHz clock domain.

## Interface
- `CLKS_PER_BIT`, default 1250, clock cycles per UART bit (12 MHz / 9600 baud); legal range 2..65535.
- `clk`  input  1  system clock, 12 MHz.
- `rst_n`  input  1  reset; one clock; reset is asynchronous and active-low.
- `send`  input  1  report request; sampled on rising `clk`.
- `score_a`  input  21  team A score, unsigned.
- `score_b`  input  21  team B score, unsigned.
- `stime`  input  5  remaining game seconds, unsigned.
- `uart_tx`  output  1  serial line; idles high.
- `busy`  output  1  high while a frame is in flight.
- `done`  output  1  one-cycle pulse at frame completion.

## Operation
- Frame, in order: `'A'`, A tens, A ones, `' '`, `'B'`, B tens, B ones, `' '`, `'T'`, T tens, T ones, CR (0x0D), LF (0x0A).
- Digits are ASCII `0x30 + d`.
- Saturation: any value > 99 is reported as `"99"`. This applies to `score_a` and `score_b` (21 bits); `stime` max is 31, so no saturation is needed for it.
- Snapshot: on acceptance, the three inputs are captured into internal registers. Later input changes do not affect the frame in flight.
- BCD conversion is done from the captured values and must complete before the byte that needs it is loaded. Either a registered /10, %10 at snapshot or an iterative converter is allowed, provided the timing below holds.
- Byte format: start bit (0), 8 data bits LSB first, stop bit (1). Ten bit-times per byte. No gap between bytes.
- State machine:
  - IDLE: `uart_tx`=1, `busy`=0. `send`=1 → LOAD.
  - LOAD: capture inputs, byte index=0 → START.
  - START: drive 0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, each CLKS_PER_BIT cycles → STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. If index<12, increment index → START; else → DONE.
  - DONE: pulse `done` for one cycle → IDLE.
- Counters: bit-time counter of width ceil(log2(CLKS_PER_BIT)), counting 0..CLKS_PER_BIT-1; 3-bit bit index; 4-bit byte index (0..12).
- `send` while `busy`=1 is ignored. There is no queue and no error flag.
- `send` held high continuously restarts a new frame on the IDLE cycle following DONE.

## Timing
- Reset values: `uart_tx`=1, `busy`=0, `done`=0. All counters are 0 and the state is IDLE.
- Reset is asynchronous. Asserting `rst_n` low mid-frame forces `uart_tx`=1 and `busy`=0 immediately, without waiting for a clock edge. The partial frame is abandoned and not resumed.
- Cycle 0: `send`=1 sampled in IDLE.
- Cycle 1: LOAD, `busy`=1, `uart_tx` still 1.
- Cycle 2: start bit begins on `uart_tx`.
- Each bit is held exactly CLKS_PER_BIT cycles.
- Frame length: 130·CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle inclusive.
- `done`=1 on the cycle after the last stop-bit cycle. `busy` falls on that same cycle.
- Earliest next acceptance: the cycle after `done`.
- `uart_tx` is driven from a register so the line is glitch-free.

## Test plan
- **Reset idle:** hold `rst_n`=0 for 5 cycles, then release → `uart_tx`=1, `busy`=0, `done`=0. No transitions for 1000 cycles.
- **Basic frame:** CLKS_PER_BIT=4, `score_a`=7, `score_b`=12, `stime`=9, pulse `send` → bench UART decoder receives "A07 B12 T09\r\n". `busy` stays high for 1+520 cycles; `done` pulses exactly once at cycle 522 after `send`.
- **Saturation:** `score_a`=150, `score_b`=99, `stime`=31 → "A99 B99 T31\r\n".
- **Snapshot and ignore:** start a frame with A=3, B=4, T=10. Change the inputs to A=50, B=60, T=0 and pulse `send` mid-frame → the first frame still reads "A03 B04 T10\r\n". No second frame follows.
- **Reset mid-frame:** assert `rst_n`=0 during the 5th byte's data bits → `uart_tx`=1 and `busy`=0 within the same cycle. After release, a new `send` yields a complete correct frame.
- **Back-to-back:** hold `send`=1 throughout → frames are separated by exactly 3 idle-high cycles (DONE, IDLE, LOAD) between the last stop bit and the next start bit. The content tracks the inputs captured at each LOAD.

Source files
------------

// File: rtl/score_report_tx.sv
// score_report_tx: 8N1 UART reporter for the scoreboard.
// Sends "Aaa Bbb Ttt\r\n" built from a snapshot taken when a report is requested.
module score_report_tx #(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [20:0] score_a,
    input  logic [20:0] score_b,
    input  logic [4:0]  stime,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [3:0]    byte_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic [3:0]    a_tens_q, a_ones_q;
    logic [3:0]    b_tens_q, b_ones_q;
    logic [3:0]    t_tens_q, t_ones_q;

    logic [3:0]    nxt_idx;
    logic [7:0]    byte_d;

    function automatic logic [6:0] sat99(input logic [20:0] v);
        return (v > 21'd99) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [3:0] tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] ones(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

    assign nxt_idx = byte_q + 4'd1;

    // Character for the byte that follows the current one.
    always_comb begin
        byte_d = 8'h0A;
        case (nxt_idx)
            4'd0:    byte_d = 8'h41;
            4'd1:    byte_d = {4'h3, a_tens_q};
            4'd2:    byte_d = {4'h3, a_ones_q};
            4'd3:    byte_d = 8'h20;
            4'd4:    byte_d = 8'h42;
            4'd5:    byte_d = {4'h3, b_tens_q};
            4'd6:    byte_d = {4'h3, b_ones_q};
            4'd7:    byte_d = 8'h20;
            4'd8:    byte_d = 8'h54;
            4'd9:    byte_d = {4'h3, t_tens_q};
            4'd10:   byte_d = {4'h3, t_ones_q};
            4'd11:   byte_d = 8'h0D;
            default: byte_d = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            a_tens_q <= '0;
            a_ones_q <= '0;
            b_tens_q <= '0;
            b_ones_q <= '0;
            t_tens_q <= '0;
            t_ones_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (send) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    a_tens_q <= tens(sat99(score_a));
                    a_ones_q <= ones(sat99(score_a));
                    b_tens_q <= tens(sat99(score_b));
                    b_ones_q <= ones(sat99(score_b));
                    t_tens_q <= tens({2'b00, stime});
                    t_ones_q <= ones({2'b00, stime});
                    byte_q   <= '0;
                    bit_q    <= '0;
                    cnt_q    <= '0;
                    shift_q  <= 8'h41;
                    tx_q     <= 1'b0;
                    state_q  <= S_START;
                end
                S_START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (byte_q < 4'd12) begin
                            byte_q  <= nxt_idx;
                            shift_q <= byte_d;
                            tx_q    <= 1'b0;
                            state_q <= S_START;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_score_report_tx.sv
// tb_score_report_tx: randomized frame checks against a text-level reference.
// Serial line is recorded per cycle and decoded as an 8N1 receiver would.
module tb_score_report_tx;

    localparam int CPB = 4;
    localparam int N   = 1200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send;
    logic [20:0] score_a, score_b;
    logic [4:0]  stime;
    logic        uart_tx, busy, done;

    logic        txs   [0:N-1];
    logic        busys [0:N-1];
    logic        dones [0:N-1];

    int          checks = 0;
    int          passes = 0;
    int unsigned na, nb, nt;

    score_report_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .send    (send),
        .score_a (score_a),
        .score_b (score_b),
        .stime   (stime),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic string exp_str(input int unsigned a, b, t);
        int unsigned sa, sb;
        sa = (a > 99) ? 99 : a;
        sb = (b > 99) ? 99 : b;
        return $sformatf("A%02d B%02d T%02d\r\n", sa, sb, t);
    endfunction

    function automatic string vis(input string s);
        string r;
        byte unsigned c;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (c < 8'd32) r = $sformatf("%s.", r);
            else r = $sformatf("%s%c", r, c);
        end
        return r;
    endfunction

    // Receiver: find start edge, sample each bit at its centre, check stop bit.
    function automatic string decode(input int from, output int first,
                                     output int nxt);
        string        s;
        int           p;
        byte unsigned ch;
        s = "";
        p = from;
        first = -1;
        nxt = N;
        for (int j = 0; j < 13; j++) begin
            while (p < N && txs[p] !== 1'b0) p++;
            if (p + 10 * CPB >= N) return s;
            if (j == 0) first = p;
            ch = 8'h00;
            for (int b = 0; b < 8; b++) ch[b] = txs[p + CPB * (b + 1) + CPB / 2];
            if (txs[p + 9 * CPB + CPB / 2] !== 1'b1) ch = 8'h3F;
            s = $sformatf("%s%c", s, ch);
            p = p + 9 * CPB + CPB / 2 + 1;
        end
        nxt = p;
        return s;
    endfunction

    task automatic start_frame(input int unsigned a, b, t);
        @(negedge clk);
        score_a = a[20:0];
        score_b = b[20:0];
        stime   = t[4:0];
        send    = 1'b1;
        txs[0]   = uart_tx;
        busys[0] = busy;
        dones[0] = done;
    endtask

    task automatic capture(input int n, input bit hold, input int chg_k);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            txs[k]   = uart_tx;
            busys[k] = busy;
            dones[k] = done;
            if (k == 1 && !hold) send = 1'b0;
            if (k == chg_k) begin
                score_a = na[20:0];
                score_b = nb[20:0];
                stime   = nt[4:0];
                send    = 1'b1;
            end
            if (k == chg_k + 1 && !hold) send = 1'b0;
        end
    endtask

    task automatic check_frame(input string name, input int unsigned a, b, t);
        string got, want;
        int    first, nxt, ndone, dpos;
        want = exp_str(a, b, t);
        got  = decode(1, first, nxt);
        ndone = 0;
        dpos  = -1;
        for (int k = 1; k <= 530; k++) if (dones[k] === 1'b1) begin
            ndone++;
            dpos = k;
        end
        checks++;
        if (got != want) $display("FAIL %s text: got '%s' want '%s'", name, vis(got), vis(want));
        else passes++;
        checks++;
        if (ndone != 1 || dpos != 522)
            $display("FAIL %s done: count %0d at %0d, want 1 at 522", name, ndone, dpos);
        else passes++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        send  = 1'b0;
        score_a = '0;
        score_b = '0;
        stime   = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_held: tx=%b busy=%b done=%b want 1 0 0", uart_tx, busy, done);
        else passes++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_release: tx=%b busy=%b done=%b want 1 0 0", uart_tx, busy, done);
        else passes++;
        begin
            int bad;
            bad = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) $display("FAIL reset_idle: %0d active cycles, want 0", bad);
            else passes++;
        end
    endtask

    task automatic test_basic;
        int nbusy, first, nxt;
        string got;
        start_frame(7, 12, 9);
        capture(530, 1'b0, 0);
        check_frame("basic", 7, 12, 9);
        got = decode(1, first, nxt);
        nbusy = 0;
        for (int k = 1; k <= 530; k++) if (busys[k] === 1'b1) nbusy++;
        checks++;
        if (nbusy != 521 || busys[1] !== 1'b1)
            $display("FAIL basic busy: %0d cycles (b1=%b), want 521 (1)", nbusy, busys[1]);
        else passes++;
        checks++;
        if (first != 2 || txs[1] !== 1'b1)
            $display("FAIL basic start: at %0d, want 2", first);
        else passes++;
    endtask

    task automatic test_saturation;
        start_frame(150, 99, 31);
        capture(530, 1'b0, 0);
        check_frame("saturation", 150, 99, 31);
        start_frame(21'h1FFFFF, 100, 0);
        capture(530, 1'b0, 0);
        check_frame("sat_max", 21'h1FFFFF, 100, 0);
    endtask

    task automatic test_random;
        int unsigned a, b, t;
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 0) ? $urandom_range(0, 120) : ($urandom & 32'h1FFFFF);
            b = (i % 2 == 1) ? $urandom_range(0, 120) : ($urandom & 32'h1FFFFF);
            t = $urandom_range(0, 31);
            start_frame(a, b, t);
            capture(530, 1'b0, 0);
            check_frame($sformatf("random%0d", i), a, b, t);
        end
    endtask

    task automatic test_snapshot;
        int extra;
        na = 50;
        nb = 60;
        nt = 0;
        start_frame(3, 4, 10);
        capture(700, 1'b0, 100);
        check_frame("snapshot", 3, 4, 10);
        extra = 0;
        for (int k = 523; k <= 700; k++) if (txs[k] !== 1'b1 || busys[k] !== 1'b0) extra++;
        checks++;
        if (extra != 0) $display("FAIL snapshot second_frame: %0d active cycles, want 0", extra);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int unsigned a, b, t;
        start_frame(45, 67, 22);
        capture(166, 1'b0, 0);
        checks++;
        if (txs[166] !== 1'b0 || busys[166] !== 1'b1)
            $display("FAIL midreset pre: tx=%b busy=%b want 0 1", txs[166], busys[166]);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL midreset async: tx=%b busy=%b want 1 0", uart_tx, busy);
        else passes++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (uart_tx !== 1'b1 || busy !== 1'b0)
            $display("FAIL midreset resume: tx=%b busy=%b want 1 0", uart_tx, busy);
        else passes++;
        a = $urandom_range(0, 99);
        b = $urandom_range(100, 5000);
        t = $urandom_range(0, 31);
        start_frame(a, b, t);
        capture(530, 1'b0, 0);
        check_frame("after_reset", a, b, t);
    endtask

    task automatic test_back_to_back;
        int unsigned a1, b1, t1;
        int f1, f2, p1, p2;
        string s1, s2;
        a1 = $urandom_range(0, 99);
        b1 = $urandom_range(0, 200);
        t1 = $urandom_range(0, 31);
        na = $urandom_range(0, 200);
        nb = $urandom_range(0, 99);
        nt = $urandom_range(0, 31);
        start_frame(a1, b1, t1);
        capture(1100, 1'b1, 10);
        s1 = decode(1, f1, p1);
        s2 = decode(p1, f2, p2);
        checks++;
        if (s1 != exp_str(a1, b1, t1))
            $display("FAIL b2b frame1: got '%s' want '%s'", vis(s1), vis(exp_str(a1, b1, t1)));
        else passes++;
        checks++;
        if (s2 != exp_str(na, nb, nt))
            $display("FAIL b2b frame2: got '%s' want '%s'", vis(s2), vis(exp_str(na, nb, nt)));
        else passes++;
        checks++;
        if (f1 != 2 || f2 != 525)
            $display("FAIL b2b starts: %0d,%0d want 2,525", f1, f2);
        else passes++;
        checks++;
        if (dones[522] !== 1'b1 || dones[1045] !== 1'b1 || dones[523] !== 1'b0)
            $display("FAIL b2b done: d522=%b d523=%b d1045=%b want 1 0 1",
                     dones[522], dones[523], dones[1045]);
        else passes++;
        checks++;
        if (busys[522] !== 1'b0 || busys[523] !== 1'b0 || busys[524] !== 1'b1)
            $display("FAIL b2b busy gap: %b%b%b want 001", busys[522], busys[523], busys[524]);
        else passes++;
        send = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_random();
        test_snapshot();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
